// File: rtl/kadai09_6.sv
// kadai09_6: 2x2 unsigned multiplier from AND partial products and two half adders,
//   with a registered product and valid flag.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   a, b  - 2-bit unsigned operands
//   z     - combinational product a*b
//   z_q   - z registered on the rising edge
//   z_vld - high once z_q holds a product captured after reset release
module kadai09_6_ha (
  input  logic i_x,
  input  logic i_y,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_x ^ i_y;
  assign o_c = i_x & i_y;
endmodule

module kadai09_6 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] z,
  output logic [3:0] z_q,
  output logic       z_vld
);
  logic w_pp00, w_pp10, w_pp01, w_pp11, w_c1;
  logic [3:0] r_z_q;
  logic       r_z_vld;
  assign w_pp00 = a[0] & b[0];
  assign w_pp10 = a[1] & b[0];
  assign w_pp01 = a[0] & b[1];
  assign w_pp11 = a[1] & b[1];
  assign z[0]   = w_pp00;
  kadai09_6_ha u_ha1 (.i_x(w_pp10), .i_y(w_pp01), .o_s(z[1]), .o_c(w_c1));
  kadai09_6_ha u_ha2 (.i_x(w_pp11), .i_y(w_c1),   .o_s(z[2]), .o_c(z[3]));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z_q   <= 4'b0000;
      r_z_vld <= 1'b0;
    end else begin
      r_z_q   <= z;
      r_z_vld <= 1'b1;
    end
  end
  assign z_q   = r_z_q;
  assign z_vld = r_z_vld;
endmodule

// File: tb/tb_kadai09_6.sv
// tb_kadai09_6: directed scoreboard bench for the 2x2 multiplier and its register stage.
module tb_kadai09_6;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] a = 2'b00;
  logic [1:0] b = 2'b00;
  logic [3:0] z, z_q;
  logic       z_vld;
  logic [3:0] q[$];
  int total = 0;
  int fails = 0;

  kadai09_6 dut (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .z(z), .z_q(z_q), .z_vld(z_vld));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_sb(input string tag, input logic [3:0] obs);
    if (q.size() == 0) begin
      total++;
      fails++;
      $error("FAIL %s: scoreboard empty, got %b, expected an entry", tag, obs);
    end else chk(tag, obs, q.pop_front());
  endtask

  task automatic drive(input logic [1:0] na, input logic [1:0] nb, input logic [3:0] exp);
    a = na;
    b = nb;
    q.push_back(exp);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("reset_z_q", z_q, 4'b0000);
    chk("reset_z_vld", {3'b000, z_vld}, 4'b0000);
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++) begin
        drive(2'(i), 2'(j), 4'(i * j));
        #10;
        chk_sb($sformatf("sweep_a%0d_b%0d", i, j), z);
      end
    drive(2'b11, 2'b11, 4'b1001); #3 chk_sb("corner_3x3", z);
    drive(2'b10, 2'b10, 4'b0100); #3 chk_sb("corner_2x2", z);
    drive(2'b00, 2'b11, 4'b0000); #3 chk_sb("corner_0x3", z);
    drive(2'b11, 2'b00, 4'b0000); #3 chk_sb("corner_3x0", z);
    drive(2'b11, 2'b10, 4'b0110); #3 chk_sb("carry_3x2", z);
    drive(2'b11, 2'b11, 4'b1001); #3 chk_sb("carry_3x3", z);
    chk("held_reset_z_q", z_q, 4'b0000);
    chk("held_reset_z_vld", {3'b000, z_vld}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b10, 2'b11, 4'b0110);
    #1 chk("pre_edge_z_vld", {3'b000, z_vld}, 4'b0000);
    @(posedge clk); #1;
    chk_sb("first_z_q", z_q);
    chk("first_z_vld", {3'b000, z_vld}, 4'b0001);
    drive(2'b01, 2'b01, 4'b0001);
    #1 chk("after_edge_z", z, 4'b0001);
    chk("z_q_held", z_q, 4'b0110);
    @(posedge clk); #1;
    chk_sb("second_z_q", z_q);
    drive(2'b11, 2'b11, 4'b1001);
    @(posedge clk); #1;
    chk_sb("third_z_q", z_q);
    #2 rst_n = 1'b0;
    #1;
    chk("async_z_q", z_q, 4'b0000);
    chk("async_z_vld", {3'b000, z_vld}, 4'b0000);
    chk("async_z", z, 4'b1001);
    @(posedge clk); #1;
    chk("reset_hold_z_q", z_q, 4'b0000);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
